// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: a single-outstanding fetch engine feeding a first-word-fall-through
// {PC,Inst} queue. A redirect flushes the queue, retargets fetch and drops any in-flight data.

module inst_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic        Out_Valid,
  output logic [31:0] Out_PC,
  output logic [31:0] Out_Inst,
  input  logic        Out_Ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               started_q, started_d;
  logic [31:0]        fpc_q, fpc_d;
  logic [31:0]        addr_q, addr_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [63:0]        entry_q [DEPTH];
  logic [63:0]        entry_d [DEPTH];

  logic               head_valid;
  logic               push;
  logic               pop;
  logic [CNT_W:0]     occ_after;
  logic               room_after;

  // State register
  always_ff @(posedge Clk or posedge Clrn) begin
    if (Clrn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; started_q holds off the first fetch by one cycle after reset release
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (started_q && !Redirect && (count_q < DEPTH_CNT)) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (Redirect) begin
          state_d = Imem_Ack ? S_IDLE : S_DROP;
        end else if (Imem_Ack && !room_after) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (Imem_Ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: fetch PC, request address, queue bookkeeping
  always_comb begin
    started_d  = 1'b1;
    pop        = head_valid && Out_Ready && !Redirect;
    push       = (state_q == S_WAIT) && Imem_Ack && !Redirect;
    occ_after  = {1'b0, count_q} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
    room_after = occ_after < {1'b0, DEPTH_CNT};

    fpc_d = fpc_q;
    if (Redirect) begin
      fpc_d = {Redirect_PC[31:2], 2'b00};
    end else if (push) begin
      fpc_d = addr_q + 32'd4;
    end

    addr_d = addr_q;
    if ((state_q == S_IDLE) && (state_d == S_WAIT)) begin
      addr_d = fpc_q;
    end else if (push && (state_d == S_WAIT)) begin
      addr_d = addr_q + 32'd4;
    end

    req_d = (state_d != S_IDLE);

    if (Redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = (push && (wr_ptr_q == PTR_W'(i))) ? {addr_q, Imem_Data} : entry_q[i];
    end
  end

  always_ff @(posedge Clk or posedge Clrn) begin
    if (Clrn) begin
      started_q <= 1'b0;
      fpc_q     <= RESET_PC;
      addr_q    <= '0;
      req_q     <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      started_q <= started_d;
      fpc_q     <= fpc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Outputs; the head is gated so an empty queue presents zeros
  always_comb begin
    head_valid = (count_q != '0);
    Imem_Req   = req_q;
    Imem_Addr  = addr_q;
    Out_Valid  = head_valid;
    Out_PC     = head_valid ? entry_q[rd_ptr_q][63:32] : 32'd0;
    Out_Inst   = head_valid ? entry_q[rd_ptr_q][31:0]  : 32'd0;
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Randomized bench for inst_prefetch_buffer: a request-level memory/pipeline model and an
// expected-instruction queue check every cycle, plus directed reset, backpressure and redirect cases.

module tb_inst_prefetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] XOR_K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic        out_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic        out_valid_w;
  logic [31:0] out_pc_w;
  logic [31:0] out_inst_w;

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .Clk(clk), .Clrn(rst), .Redirect(redirect), .Redirect_PC(redirect_pc),
    .Imem_Req(imem_req), .Imem_Addr(imem_addr), .Imem_Ack(imem_ack), .Imem_Data(imem_data),
    .Out_Valid(out_valid), .Out_PC(out_pc), .Out_Inst(out_inst), .Out_Ready(out_ready)
  );

  // Second instance: always-ready memory, no consumer, fetch starting just below the wrap point
  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .Clk(clk), .Clrn(rst), .Redirect(1'b0), .Redirect_PC(32'd0),
    .Imem_Req(imem_req_w), .Imem_Addr(imem_addr_w), .Imem_Ack(imem_req_w),
    .Imem_Data(imem_addr_w ^ XOR_K),
    .Out_Valid(out_valid_w), .Out_PC(out_pc_w), .Out_Inst(out_inst_w), .Out_Ready(1'b0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [63:0] q[$];
  logic [31:0] exp_fpc = 32'd0;
  bit          pending = 0;
  bit          tainted = 0;
  int          remain = 0;
  logic [31:0] pend_addr = 32'd0;
  int          n_push = 0;
  int          n_req = 0;
  logic [31:0] last_req_addr = 32'd0;

  // Stimulus knobs
  int          p_redir = 0;
  int          p_ready = 100;
  int          min_lat = 1;
  int          max_lat = 1;
  int          force_mode = 0;
  logic [31:0] force_pc = 32'd0;
  bit          fired = 0;

  // dut_w fetch log
  logic [31:0] w_addr [3];
  int          n_w = 0;

  always @(negedge clk) begin
    if (!rst && imem_req_w && n_w < 3) begin
      w_addr[n_w] = imem_addr_w;
      n_w++;
    end
  end

  // One cycle: called at a negedge, checks outputs, drives inputs, advances the model, returns at next negedge
  task automatic step();
    logic [63:0] head;
    bit          do_push;
    bit          do_pop;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      head = q[0];
      check("out_pc", out_pc, head[63:32]);
      check("out_inst", out_inst, head[31:0]);
    end
    if (q.size() == DEPTH) check("req_when_full", 32'(imem_req), 32'd0);

    imem_ack = 1'b0;
    if (pending) begin
      check("addr_hold", imem_addr, pend_addr);
      check("req_hold", 32'(imem_req), 32'd1);
    end else if (imem_req) begin
      pending = 1;
      tainted = 0;
      pend_addr = imem_addr;
      remain = $urandom_range(min_lat, max_lat);
      check("fetch_addr", imem_addr, exp_fpc);
      n_req++;
      last_req_addr = imem_addr;
    end
    if (pending) begin
      remain--;
      if (remain == 0) imem_ack = 1'b1;
    end
    imem_data = imem_ack ? (pend_addr ^ XOR_K) : $urandom();

    out_ready = ($urandom_range(0, 99) < p_ready);
    redirect  = ($urandom_range(0, 99) < p_redir);
    if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000C);
    else                           redirect_pc = $urandom() & 32'hFFFF_FFFC;
    if ((force_mode == 1 && pending && !imem_ack) ||
        (force_mode == 2 && imem_ack && q.size() != 0)) begin
      redirect = 1'b1;
      redirect_pc = force_pc;
      out_ready = 1'b1;
      force_mode = 0;
      fired = 1;
    end

    do_pop  = (q.size() != 0) && out_ready && !redirect;
    do_push = imem_ack && !redirect && !tainted;
    if (redirect) begin
      q.delete();
      exp_fpc = redirect_pc;
      if (pending) tainted = 1;
    end else begin
      if (do_pop) begin
        head = q.pop_front();
        $display("pop pc=%h inst=%h", head[63:32], head[31:0]);
      end
      if (do_push) begin
        q.push_back({pend_addr, pend_addr ^ XOR_K});
        exp_fpc = pend_addr + 32'd4;
        n_push++;
        check("no_overflow", 32'(q.size() > DEPTH), 32'd0);
      end
    end
    if (imem_ack) pending = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse taken mid-cycle; optionally an ack arrives right after release
  task automatic do_reset(input bit late_ack);
    #2 rst = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    redirect = 1'b0;
    imem_ack = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = late_ack;
    imem_data = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    check("req_low_edge1", 32'(imem_req), 32'd0);
    check("late_ack_valid", 32'(out_valid), 32'd0);
    check("late_ack_pc", out_pc, 32'd0);
    check("late_ack_inst", out_inst, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("req_rise_edge2", 32'(imem_req), 32'd1);
    q.delete();
    pending = 0;
    tainted = 0;
    exp_fpc = 32'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset(0);

    // Streaming with a 1-cycle memory and a always-ready consumer: one entry per cycle, no gaps
    p_redir = 0; p_ready = 100; min_lat = 1; max_lat = 1; n_push = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) check("a_no_gap", 32'(out_valid), 32'd1);
      step();
    end
    check("a_pushes", 32'(n_push), 32'd20);

    // Consumer stalled: exactly DEPTH entries, then fetching stops
    do_reset(0);
    p_ready = 0; n_push = 0;
    repeat (12) step();
    check("b_pushes", 32'(n_push), 32'd4);
    check("b_req_idle", 32'(imem_req), 32'd0);
    check("b_head_pc", out_pc, 32'd0);

    // Redirect while a 3-cycle fetch is outstanding
    do_reset(0);
    p_ready = 100; min_lat = 3; max_lat = 3;
    repeat (8) step();
    force_pc = 32'h0000_0100; force_mode = 1; fired = 0;
    for (int i = 0; i < 20 && !fired; i++) step();
    check("c_fired", 32'(fired), 32'd1);
    for (int i = 0; i < 30 && !out_valid; i++) step();
    check("c_next_pc", out_pc, 32'h0000_0100);

    // Redirect coinciding with an ack while the head is being consumed
    min_lat = 1; max_lat = 1;
    repeat (5) step();
    force_pc = 32'h0000_2000; force_mode = 2; fired = 0;
    for (int i = 0; i < 20 && !fired; i++) step();
    check("d_fired", 32'(fired), 32'd1);
    check("d_flushed", 32'(out_valid), 32'd0);
    begin
      int req_before;
      req_before = n_req;
      for (int i = 0; i < 10 && n_req == req_before; i++) step();
      check("d_next_fetch", last_req_addr, 32'h0000_2000);
    end

    // Random traffic with periodic resets landing mid-request
    p_redir = 6; p_ready = 70; min_lat = 1; max_lat = 4;
    for (int r = 0; r < 4; r++) begin
      repeat (500) step();
      for (int i = 0; i < 20 && !pending; i++) step();
      check("e_mid_request", 32'(pending), 32'd1);
      do_reset(1);
    end
    repeat (50) step();

    check("w_count", 32'(n_w), 32'd3);
    check("w_addr0", w_addr[0], 32'hFFFF_FFF8);
    check("w_addr1", w_addr[1], 32'hFFFF_FFFC);
    check("w_addr2", w_addr[2], 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_buffer.md
INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the queue entry count (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-004 SHALL have port Clk, input, 1 bit, the rising-edge clock.
REQ-005 SHALL have port Clrn, input, 1 bit, the asynchronous active-high reset (1 = reset).
REQ-006 SHALL have port Redirect, input, 1 bit: a taken branch or jump from ID.
REQ-007 SHALL have port Redirect_PC, input, 32 bits: the new fetch target, sampled when Redirect=1.
REQ-008 SHALL have port Imem_Req, output, 1 bit: instruction-memory read request.
REQ-009 SHALL have port Imem_Addr, output, 32 bits: the read address, word-aligned.
REQ-010 SHALL have port Imem_Ack, input, 1 bit: Imem_Data is valid this cycle.
REQ-011 SHALL have port Imem_Data, input, 32 bits: the returned instruction.
REQ-012 SHALL have port Out_Valid, output, 1 bit: the queue head is valid for the IF/ID register.
REQ-013 SHALL have port Out_PC, output, 32 bits: the head instruction address.
REQ-014 SHALL have port Out_Inst, output, 32 bits: the head instruction.
REQ-015 SHALL have port Out_Ready, input, 1 bit: pipeline accepts the head (driven by wpcir).

Function
REQ-016 SHALL hold fetch PC (Fpc), a DEPTH-entry FIFO of {PC,Inst}, a count of 0..DEPTH, and a state in {IDLE, WAIT, DROP}.
REQ-017 SHALL drive Imem_Req=1 exactly in WAIT and DROP, with Imem_Addr and Imem_Req registered and Imem_Addr stable until Imem_Ack.
REQ-018 SHALL allow at most one outstanding memory request; memory latency of 1..N cycles is supported.
REQ-019 IDLE->WAIT when count<DEPTH and Redirect=0, with Imem_Addr<=Fpc.
REQ-020 In WAIT, on Imem_Ack with Redirect=0: push {Imem_Addr, Imem_Data}; Fpc<=Imem_Addr+4; stay in WAIT with the new address if (count+1-pop)<DEPTH, else go to IDLE.
REQ-021 SHALL be FWFT: a pushed entry appears on Out_Valid/Out_PC/Out_Inst the cycle after Imem_Ack (one-cycle latency).
REQ-022 SHALL pop when Out_Valid=1 and Out_Ready=1; Out_Ready is ignored when Out_Valid=0.
REQ-023 On simultaneous push and pop, count SHALL be unchanged and entry order preserved.
REQ-024 SHALL NOT push when count=DEPTH; REQ-019/020 guarantee this, and an overflow is a verification error.
REQ-025 SHALL apply Redirect in any state: FIFO flushed (count<=0, Out_Valid<=0 next cycle), Fpc<=Redirect_PC, and any same-cycle pop or push discarded.
REQ-026 Redirect in WAIT without Imem_Ack SHALL go to DROP, keeping Imem_Req/Imem_Addr until ack.
REQ-027 DROP SHALL discard the acked data and then go to IDLE; a further Redirect in DROP updates Fpc only.
REQ-028 Redirect in WAIT with Imem_Ack in the same cycle SHALL discard the data and go to IDLE.
REQ-029 Fpc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 Clrn=1 SHALL immediately force: state=IDLE, Fpc=RESET_PC, count=0, pointers=0, Imem_Req=0, Imem_Addr=0, Out_Valid=0, Out_PC=0, Out_Inst=0.
REQ-032 A reset asserted mid-request SHALL abandon the request; an Imem_Ack arriving after reset release while in IDLE is ignored.
REQ-033 The first Imem_Req SHALL rise on the second rising edge after Clrn deasserts.

Verification
REQ-034 Reset release, 1-cycle-ack memory returning Inst=Addr^32'hA5A5_0000, Out_Ready=1 -> Out_PC sequence 0,4,8,... with matching Out_Inst, no gaps after the first entry.
REQ-035 Out_Ready=0 throughout -> exactly 4 entries (PCs 0,4,8,C) held, Imem_Req=0 after the fourth ack, no overflow.
REQ-036 Redirect to 32'h0000_0100 while in WAIT with a 3-cycle ack -> the in-flight data is dropped and the next Out_PC is 0x100.
REQ-037 Redirect and Imem_Ack in the same cycle, with Out_Valid=1 and Out_Ready=1 -> FIFO empty next cycle, the ack is not pushed, and the next fetch is at Redirect_PC.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> fetches at FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 Clrn pulsed mid-WAIT with a late Imem_Ack after release -> no push, and outputs are at their reset values.
